// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU datapath blocks and the controller.
//   - fetch_state_t : instruction-fetch FSM states
//   - CPU_*_W       : default datapath widths
//   - OPC_*         : opcode encodings understood by cpu_controller
package cpu_pkg;

  localparam int CPU_PC_W    = 8;
  localparam int CPU_INSTR_W = 16;
  localparam int CPU_OPC_W   = 4;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  // Opcode map (top CPU_OPC_W bits of an instruction).
  localparam logic [CPU_OPC_W-1:0] OPC_NOP   = 4'h0;
  localparam logic [CPU_OPC_W-1:0] OPC_LOAD  = 4'h1;
  localparam logic [CPU_OPC_W-1:0] OPC_STORE = 4'h2;
  localparam logic [CPU_OPC_W-1:0] OPC_ADD   = 4'h3;
  localparam logic [CPU_OPC_W-1:0] OPC_SUB   = 4'h4;
  localparam logic [CPU_OPC_W-1:0] OPC_AND   = 4'h5;
  localparam logic [CPU_OPC_W-1:0] OPC_OR    = 4'h6;
  localparam logic [CPU_OPC_W-1:0] OPC_XOR   = 4'h7;
  localparam logic [CPU_OPC_W-1:0] OPC_JMP   = 4'h8;
  localparam logic [CPU_OPC_W-1:0] OPC_JZ    = 4'h9;
  localparam logic [CPU_OPC_W-1:0] OPC_JNZ   = 4'hA;
  localparam logic [CPU_OPC_W-1:0] OPC_HALT  = 4'hF;

endpackage

// File: rtl/cpu_pc_counter.sv
// cpu_pc_counter: program counter register.
//   clk, rst_n : clock, asynchronous active-low reset (pc -> RESET_VAL)
//   en         : gates both load and inc
//   load       : pc <= load_val (wins over inc)
//   inc        : pc <= pc + 1, wrapping modulo 2^W
//   load_val   : branch target
//   pc         : current program counter (registered)
module cpu_pc_counter #(
  parameter int           W         = 8,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] pc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] pc_reg;
  logic [W-1:0] pc_next;

  always_comb begin
    pc_next = pc_reg;
    if (en) begin
      if (load) begin
        pc_next = load_val;
      end else if (inc) begin
        // Natural W-bit overflow gives the required wrap to zero.
        pc_next = pc_reg + ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= RESET_VAL;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: instruction-fetch responder for cpu_controller.
// Owns PC and IR, runs one outstanding req/ack read against instruction
// memory and reports the fetched opcode back to the controller.
//   clk, rst_n           : clock, asynchronous active-low reset
//   en                   : strobe enable (loadPC/incPC/loadIR ignored when 0)
//   loadPC, incPC        : PC load (priority) / increment
//   loadIR               : start a fetch at the current PC
//   jump_addr            : branch target for loadPC
//   mem_req, mem_addr    : read request / address, held until mem_ack
//   mem_ack, mem_rdata   : read data strobe / data
//   opcode_out           : IR[INSTR_W-1 -: OPC_W]
//   operand_out          : IR low field
//   pc_out               : current PC
//   busy                 : fetch outstanding
//   ovr                  : sticky, loadIR seen while a fetch was outstanding
module cpu_fetch_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W     = CPU_PC_W,
  parameter int              INSTR_W  = CPU_INSTR_W,
  parameter int              OPC_W    = CPU_OPC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     loadPC,
  input  logic                     incPC,
  input  logic                     loadIR,
  input  logic [PC_W-1:0]          jump_addr,
  output logic                     mem_req,
  output logic [PC_W-1:0]          mem_addr,
  input  logic                     mem_ack,
  input  logic [INSTR_W-1:0]       mem_rdata,
  output logic [OPC_W-1:0]         opcode_out,
  output logic [INSTR_W-OPC_W-1:0] operand_out,
  output logic [PC_W-1:0]          pc_out,
  output logic                     busy,
  output logic                     ovr
);

  fetch_state_t        state_reg;
  fetch_state_t        state_next;
  logic [PC_W-1:0]     addr_reg;
  logic [PC_W-1:0]     addr_next;
  logic [INSTR_W-1:0]  ir_reg;
  logic [INSTR_W-1:0]  ir_next;
  logic                ovr_reg;
  logic                ovr_next;
  logic [PC_W-1:0]     pc_cur;

  // PC lives in its own block so the branch unit can reuse it.
  cpu_pc_counter #(
    .W         (PC_W),
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .load     (loadPC),
    .inc      (incPC),
    .load_val (jump_addr),
    .pc       (pc_cur)
  );

  // Next-state logic. The address latch captures pc_cur, which is the PC
  // before any same-edge loadPC/incPC, so a FETCH cycle (loadIR+incPC)
  // reads the old PC while the counter advances.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    ir_next    = ir_reg;
    ovr_next   = ovr_reg;
    unique case (state_reg)
      FETCH_IDLE: begin
        if (en && loadIR) begin
          state_next = FETCH_REQ;
          addr_next  = pc_cur;
        end
      end
      FETCH_REQ: begin
        // Completion does not depend on en: the bus is never abandoned.
        if (mem_ack) begin
          ir_next    = mem_rdata;
          state_next = FETCH_IDLE;
        end
        if (en && loadIR) begin
          ovr_next = 1'b1;
        end
      end
      default: begin
        state_next = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FETCH_IDLE;
      addr_reg  <= '0;
      ir_reg    <= '0;
      ovr_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      ir_reg    <= ir_next;
      ovr_reg   <= ovr_next;
    end
  end

  // Outputs decode flops only; nothing flows combinationally from inputs.
  assign mem_req     = (state_reg == FETCH_REQ);
  assign busy        = (state_reg == FETCH_REQ);
  assign mem_addr    = addr_reg;
  assign opcode_out  = ir_reg[INSTR_W-1 -: OPC_W];
  assign operand_out = ir_reg[INSTR_W-OPC_W-1:0];
  assign pc_out      = pc_cur;
  assign ovr         = ovr_reg;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
module tb_cpu_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        loadPC;
  logic        incPC;
  logic        loadIR;
  logic [7:0]  jump_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [3:0]  opcode_out;
  logic [11:0] operand_out;
  logic [7:0]  pc_out;
  logic        busy;
  logic        ovr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cpu_fetch_unit #(
    .PC_W     (8),
    .INSTR_W  (16),
    .OPC_W    (4),
    .RESET_PC (8'h10)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .loadPC      (loadPC),
    .incPC       (incPC),
    .loadIR      (loadIR),
    .jump_addr   (jump_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .opcode_out  (opcode_out),
    .operand_out (operand_out),
    .pc_out      (pc_out),
    .busy        (busy),
    .ovr         (ovr)
  );

  // Inputs change and outputs are sampled on the falling edge only.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    en = 1'b1; loadPC = 1'b0; incPC = 1'b0; loadIR = 1'b0;
    jump_addr = 8'h00; mem_ack = 1'b0; mem_rdata = 16'h0000;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (pc_out !== 8'h10) begin errors++; $display("FAIL reset_pc_in_reset: got %h expected 10", pc_out); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req_in_reset: got %b expected 0", mem_req); end
    rst_n = 1'b1;
    step();
    checks++; if (pc_out !== 8'h10) begin errors++; $display("FAIL reset_pc: got %h expected 10", pc_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (opcode_out !== 4'h0) begin errors++; $display("FAIL reset_opcode: got %h expected 0", opcode_out); end
    checks++; if (operand_out !== 12'h000) begin errors++; $display("FAIL reset_operand: got %h expected 000", operand_out); end
    checks++; if (mem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", mem_addr); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    $display("reset: pc=%h busy=%b req=%b", pc_out, busy, mem_req);
  endtask

  task automatic test_zero_wait();
    loadIR = 1'b1; incPC = 1'b1;
    step();
    loadIR = 1'b0; incPC = 1'b0;
    checks++; if (mem_addr !== 8'h10) begin errors++; $display("FAIL zw_addr: got %h expected 10", mem_addr); end
    checks++; if (pc_out !== 8'h11) begin errors++; $display("FAIL zw_pc: got %h expected 11", pc_out); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zw_busy_high: got %b expected 1", busy); end
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL zw_req_high: got %b expected 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 16'h9ABC;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++; if (opcode_out !== 4'h9) begin errors++; $display("FAIL zw_opcode: got %h expected 9", opcode_out); end
    checks++; if (operand_out !== 12'hABC) begin errors++; $display("FAIL zw_operand: got %h expected abc", operand_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zw_busy_low: got %b expected 0", busy); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL zw_req_low: got %b expected 0", mem_req); end
    $display("zero_wait: addr=10 opcode=%h operand=%h", opcode_out, operand_out);
  endtask

  task automatic test_wait_states(input int waits, input logic [15:0] data, input logic [7:0] exp_addr);
    int req_cycles = 0;
    loadIR = 1'b1;
    step();
    loadIR = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL ws_addr_stable cycle %0d: got %h expected %h", i, mem_addr, exp_addr); end
      if (i == waits) begin mem_ack = 1'b1; mem_rdata = data; end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++; if (req_cycles !== waits + 1) begin errors++; $display("FAIL ws_req_cycles: got %0d expected %0d", req_cycles, waits + 1); end
    checks++; if (opcode_out !== data[15:12]) begin errors++; $display("FAIL ws_opcode: got %h expected %h", opcode_out, data[15:12]); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL ws_req_low: got %b expected 0", mem_req); end
    $display("wait_states=%0d: addr=%h opcode=%h req_cycles=%0d", waits, exp_addr, opcode_out, req_cycles);
  endtask

  task automatic test_overrun();
    int rises = 0;
    logic prev = 1'b0;
    loadIR = 1'b1;
    step();
    if (mem_req === 1'b1 && prev === 1'b0) rises++;
    prev = mem_req;
    step();   // loadIR still high, now in REQ
    loadIR = 1'b0;
    if (mem_req === 1'b1 && prev === 1'b0) rises++;
    prev = mem_req;
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", ovr); end
    mem_ack = 1'b1; mem_rdata = 16'h3000;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (mem_req === 1'b1 && prev === 1'b0) rises++;
      prev = mem_req;
      step();
    end
    checks++; if (rises !== 1) begin errors++; $display("FAIL ovr_single_req: got %0d rises expected 1", rises); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", ovr); end
    checks++; if (opcode_out !== 4'h3) begin errors++; $display("FAIL ovr_opcode: got %h expected 3", opcode_out); end
    $display("overrun: ovr=%b rises=%0d", ovr, rises);
  endtask

  task automatic test_load_priority();
    loadPC = 1'b1; incPC = 1'b1; jump_addr = 8'h40;
    step();
    loadPC = 1'b0; incPC = 1'b0;
    checks++; if (pc_out !== 8'h40) begin errors++; $display("FAIL load_priority: got %h expected 40", pc_out); end
    $display("load_priority: pc=%h", pc_out);
  endtask

  task automatic test_en_low();
    loadPC = 1'b1; jump_addr = 8'h55;
    step();
    loadPC = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      loadIR = 1'b1; incPC = 1'b1; loadPC = (i == 1); jump_addr = 8'hEE;
      step();
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL en_low_req cycle %0d: got %b expected 0", i, mem_req); end
      checks++; if (pc_out !== 8'h55) begin errors++; $display("FAIL en_low_pc cycle %0d: got %h expected 55", i, pc_out); end
    end
    loadIR = 1'b0; incPC = 1'b0; loadPC = 1'b0;
    // Start a fetch, then drop en while it is outstanding.
    en = 1'b1; loadIR = 1'b1;
    step();
    en = 1'b0; loadIR = 1'b0; incPC = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL en_drop_req_held: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 8'h55) begin errors++; $display("FAIL en_drop_addr: got %h expected 55", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 16'h7123;
    step();
    mem_ack = 1'b0; incPC = 1'b0;
    checks++; if (opcode_out !== 4'h7) begin errors++; $display("FAIL en_drop_opcode: got %h expected 7", opcode_out); end
    checks++; if (operand_out !== 12'h123) begin errors++; $display("FAIL en_drop_operand: got %h expected 123", operand_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_drop_busy: got %b expected 0", busy); end
    checks++; if (pc_out !== 8'h55) begin errors++; $display("FAIL en_drop_pc: got %h expected 55", pc_out); end
    en = 1'b1;
    $display("en_low: pc=%h opcode=%h", pc_out, opcode_out);
  endtask

  task automatic test_wrap();
    loadPC = 1'b1; jump_addr = 8'hFF;
    step();
    loadPC = 1'b0;
    checks++; if (pc_out !== 8'hFF) begin errors++; $display("FAIL wrap_load: got %h expected ff", pc_out); end
    incPC = 1'b1;
    step();
    incPC = 1'b0;
    checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL wrap_inc: got %h expected 00", pc_out); end
    $display("wrap: pc=%h", pc_out);
  endtask

  task automatic test_reset_mid_req();
    loadIR = 1'b1;
    step();
    loadIR = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rmr_req_before: got %b expected 1", mem_req); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmr_req_drop: got %b expected 0", mem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmr_busy_drop: got %b expected 0", busy); end
    checks++; if (pc_out !== 8'h10) begin errors++; $display("FAIL rmr_pc: got %h expected 10", pc_out); end
    step();
    rst_n = 1'b1;
    step();
    // Stray acknowledge while idle must not touch IR.
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    checks++; if (opcode_out !== 4'h0) begin errors++; $display("FAIL stray_ack_opcode: got %h expected 0", opcode_out); end
    checks++; if (operand_out !== 12'h000) begin errors++; $display("FAIL stray_ack_operand: got %h expected 000", operand_out); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL stray_ack_req: got %b expected 0", mem_req); end
    $display("reset_mid_req: req=%b opcode=%h", mem_req, opcode_out);
  endtask

  // Transaction-level model: memory image, PC as an integer, and a
  // single outstanding fetch with a wait-state countdown.
  task automatic test_random();
    logic [15:0] mem [256];
    int          pc_m;
    logic [15:0] ir_m;
    bit          busy_m;
    bit          ovr_m;
    int          addr_m;
    int          wait_left;
    bit          was_busy;
    int          fetches = 0;
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    for (int it = 0; it < 400; it++) begin
      if (it % 100 == 0) begin
        do_reset();
        pc_m = 16; ir_m = 16'h0000; busy_m = 0; ovr_m = 0; addr_m = 0; wait_left = 0;
      end
      en        = ($urandom_range(0, 7) != 0);
      loadPC    = ($urandom_range(0, 7) == 0);
      incPC     = ($urandom_range(0, 2) == 0);
      loadIR    = ($urandom_range(0, 2) == 0);
      jump_addr = 8'($urandom_range(0, 255));
      if (busy_m) begin
        mem_ack   = (wait_left == 0);
        mem_rdata = mem[addr_m];
      end else begin
        mem_ack   = ($urandom_range(0, 4) == 0);
        mem_rdata = 16'($urandom);
      end
      step();
      was_busy = busy_m;
      if (was_busy) begin
        if (mem_ack) begin
          ir_m = mem[addr_m];
          busy_m = 0;
          fetches++;
          $display("rand fetch %0d: addr=%h data=%h", fetches, addr_m[7:0], ir_m);
        end else begin
          wait_left--;
        end
      end
      if (en && loadIR) begin
        if (was_busy) begin
          ovr_m = 1;
        end else begin
          busy_m = 1;
          addr_m = pc_m;
          wait_left = $urandom_range(0, 3);
        end
      end
      if (en) begin
        if (loadPC) pc_m = jump_addr;
        else if (incPC) pc_m = (pc_m + 1) % 256;
      end
      checks++; if (pc_out !== 8'(pc_m)) begin errors++; $display("FAIL rand_pc it %0d: got %h expected %h", it, pc_out, 8'(pc_m)); end
      checks++; if (mem_req !== busy_m) begin errors++; $display("FAIL rand_req it %0d: got %b expected %b", it, mem_req, busy_m); end
      checks++; if (busy !== busy_m) begin errors++; $display("FAIL rand_busy it %0d: got %b expected %b", it, busy, busy_m); end
      checks++; if (mem_addr !== 8'(addr_m)) begin errors++; $display("FAIL rand_addr it %0d: got %h expected %h", it, mem_addr, 8'(addr_m)); end
      checks++; if (opcode_out !== ir_m[15:12]) begin errors++; $display("FAIL rand_opcode it %0d: got %h expected %h", it, opcode_out, ir_m[15:12]); end
      checks++; if (operand_out !== ir_m[11:0]) begin errors++; $display("FAIL rand_operand it %0d: got %h expected %h", it, operand_out, ir_m[11:0]); end
      checks++; if (ovr !== ovr_m) begin errors++; $display("FAIL rand_ovr it %0d: got %b expected %b", it, ovr, ovr_m); end
    end
    clear_inputs();
    $display("random: %0d fetches completed", fetches);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states(3, 16'hA123, 8'h11);
    test_overrun();
    test_load_priority();
    test_en_low();
    test_wrap();
    test_reset_mid_req();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
